// File: rtl/pixel_scheduler_if.sv
// Pixel request/result handshake toward the raytracer plus the valid/ready result stream.
interface pixel_scheduler_if;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        pixel_valid;
    logic        rt_done;
    logic [23:0] rt_rgb;
    logic        pix_valid;
    logic        pix_ready;
    logic [23:0] pix_data;
    logic        pix_sof;
    logic        pix_eol;

    modport master (
        output pixel_x, pixel_y, pixel_valid, pix_valid, pix_data, pix_sof, pix_eol,
        input  rt_done, rt_rgb, pix_ready
    );

    modport slave (
        input  pixel_x, pixel_y, pixel_valid, pix_valid, pix_data, pix_sof, pix_eol,
        output rt_done, rt_rgb, pix_ready
    );
endinterface

// File: rtl/pixel_scheduler.sv
// Raster-order pixel request scheduler with timeout substitution and a result FIFO.
// Optional frame CRC-16/CCITT enabled by defining PIXEL_SCHED_CRC_EN.
module pixel_scheduler #(
    parameter int unsigned H_RES      = 320,
    parameter int unsigned V_RES      = 240,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned TIMEOUT    = 1023,
    parameter logic [23:0] BG_RGB     = 24'h000020
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     frame_restart,
    pixel_scheduler_if.master        bus,
    output logic                     frame_done,
    output logic                     timeout_err,
    output logic [15:0]              frame_crc
);
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_STALL = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_WAIT  = 2'd3;

    typedef struct packed {
        logic [23:0] rgb;
        logic        sof;
        logic        eol;
    } entry_t;

    logic [1:0]    state, state_next;
    logic [9:0]    x_q, y_q;
    logic [TW-1:0] timer;
    entry_t        mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_next;
    logic          pixel_valid_q, pix_valid_q;
    logic          push, pop, timed_out, last_x, last_y, fifo_full;

    // Next state and FIFO bookkeeping; a slot is reserved at ISSUE so push never overflows.
    always_comb begin
        state_next = state;
        last_x     = (x_q == 10'(H_RES - 1));
        last_y     = (y_q == 10'(V_RES - 1));
        fifo_full  = (count == CW'(FIFO_DEPTH));
        timed_out  = (timer == TW'(TIMEOUT));
        pop        = pix_valid_q && bus.pix_ready;
        push       = (state == S_WAIT) && !frame_restart && (bus.rt_done || timed_out);
        count_next = frame_restart ? '0 : (count + CW'(push) - CW'(pop));

        case (state)
            S_IDLE:  if (enable) state_next = fifo_full ? S_STALL : S_ISSUE;
            S_STALL: begin
                if (!enable)        state_next = S_IDLE;
                else if (!fifo_full) state_next = S_ISSUE;
            end
            S_ISSUE: state_next = S_WAIT;
            S_WAIT: begin
                if (push) begin
                    if (!enable)                              state_next = S_IDLE;
                    else if (count_next == CW'(FIFO_DEPTH))   state_next = S_STALL;
                    else                                      state_next = S_ISSUE;
                end
            end
            default: state_next = S_IDLE;
        endcase

        if (frame_restart) state_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Coordinates, timer, FIFO storage and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q           <= '0;
            y_q           <= '0;
            timer         <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            pixel_valid_q <= 1'b0;
            pix_valid_q   <= 1'b0;
            frame_done    <= 1'b0;
            timeout_err   <= 1'b0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
        end else begin
            pixel_valid_q <= (state_next == S_ISSUE);
            pix_valid_q   <= (count_next != '0);
            count         <= count_next;
            frame_done    <= push && last_x && last_y;

            if (state == S_ISSUE)     timer <= '0;
            else if (state == S_WAIT) timer <= timer + TW'(1);

            if (frame_restart) begin
                x_q         <= '0;
                y_q         <= '0;
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                timeout_err <= 1'b0;
            end else begin
                if (push) begin
                    mem[wr_ptr].rgb <= bus.rt_done ? bus.rt_rgb : BG_RGB;
                    mem[wr_ptr].sof <= (x_q == '0) && (y_q == '0);
                    mem[wr_ptr].eol <= last_x;
                    wr_ptr          <= wr_ptr + AW'(1);
                    if (!bus.rt_done) timeout_err <= 1'b1;
                    if (last_x) begin
                        x_q <= '0;
                        y_q <= last_y ? 10'd0 : (y_q + 10'd1);
                    end else begin
                        x_q <= x_q + 10'd1;
                    end
                end
                if (pop) rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    assign bus.pixel_x     = x_q;
    assign bus.pixel_y     = y_q;
    assign bus.pixel_valid = pixel_valid_q;
    assign bus.pix_valid   = pix_valid_q;
    assign bus.pix_data    = mem[rd_ptr].rgb;
    assign bus.pix_sof     = mem[rd_ptr].sof;
    assign bus.pix_eol     = mem[rd_ptr].eol;

`ifdef PIXEL_SCHED_CRC_EN
    logic [FIFO_DEPTH-1:0] last_line;
    logic [15:0]           crc_acc;
    logic [15:0]           crc_next;

    function automatic logic [15:0] crc24(input logic [15:0] c_in, input logic [23:0] d);
        logic [15:0] c;
        c = c_in;
        for (int i = 23; i >= 0; i--) begin
            c = (c[15] ^ d[i]) ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
        end
        return c;
    endfunction

    always_comb crc_next = crc24(bus.pix_sof ? 16'hFFFF : crc_acc, bus.pix_data);

    // Accumulate over popped pixels; latch on the end of the frame's final line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_line <= '0;
            crc_acc   <= 16'hFFFF;
            frame_crc <= 16'h0000;
        end else begin
            if (push) last_line[wr_ptr] <= last_y;
            if (frame_restart) begin
                crc_acc <= 16'hFFFF;
            end else if (pop) begin
                crc_acc <= crc_next;
                if (bus.pix_eol && last_line[rd_ptr]) frame_crc <= crc_next;
            end
        end
    end
`else
    assign frame_crc = 16'h0000;
`endif

endmodule

// File: tb/tb_pixel_scheduler.sv
// Directed bench for pixel_scheduler: raster walk, timeout, backpressure, race, abort, CRC.
module tb_pixel_scheduler;
    localparam int unsigned H  = 4;
    localparam int unsigned V  = 2;
    localparam int unsigned D  = 4;
    localparam int unsigned TO = 15;
    localparam logic [23:0] BG = 24'h000020;

    typedef struct packed {
        logic [23:0] rgb;
        logic        sof;
        logic        eol;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        frame_restart;
    logic        frame_done;
    logic        timeout_err;
    logic [15:0] frame_crc;

    pixel_scheduler_if bus();

    pixel_scheduler #(
        .H_RES(H), .V_RES(V), .FIFO_DEPTH(D), .TIMEOUT(TO), .BG_RGB(BG)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .frame_restart(frame_restart),
        .bus(bus), .frame_done(frame_done), .timeout_err(timeout_err), .frame_crc(frame_crc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    exp_t sb[$];
    int exp_x = 0, exp_y = 0;
    int req_cnt = 0, req_total = 0, pops = 0, frames = 0;
    int last_x = 0, last_y = 0;
    int rt_delay = 1, rt_cnt = 0;
    bit rt_never = 0, rt_all_ones = 0, late_fired = 0;
    logic [23:0] pend_rgb;
    exp_t mon_e, mdl_e;
    logic [23:0] mdl_rgb;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] crc_word(input logic [15:0] c_in, input logic [23:0] w);
        logic [15:0] c;
        c = c_in;
        for (int b = 23; b >= 0; b--) begin
            c = {c[14:0], 1'b0} ^ ((c[15] ^ w[b]) ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    // Raytracer model: answers rt_delay cycles after each request and records the expected push.
    always @(negedge clk) begin
        bus.rt_done = 1'b0;
        bus.rt_rgb  = 24'hDEAD00;
        if (rt_cnt > 0) begin
            rt_cnt--;
            if (rt_cnt == 0) begin
                bus.rt_done = 1'b1;
                bus.rt_rgb  = pend_rgb;
                late_fired  = 1'b1;
            end
        end
        if (rst_n && bus.pixel_valid) begin
            check("req_x", 32'(bus.pixel_x), 32'(exp_x));
            check("req_y", 32'(bus.pixel_y), 32'(exp_y));
            last_x = int'(bus.pixel_x);
            last_y = int'(bus.pixel_y);
            mdl_rgb = rt_all_ones ? 24'hFFFFFF
                                  : {(8'h80 | 8'(req_total)), 6'd0, 5'(exp_x), 5'(exp_y)};
            mdl_e.rgb = rt_never ? BG : mdl_rgb;
            mdl_e.sof = (exp_x == 0) && (exp_y == 0);
            mdl_e.eol = (exp_x == int'(H) - 1);
            sb.push_back(mdl_e);
            if (exp_x == int'(H) - 1) begin
                exp_x = 0;
                exp_y = (exp_y == int'(V) - 1) ? 0 : exp_y + 1;
            end else begin
                exp_x++;
            end
            req_cnt++;
            req_total++;
            if (!rt_never) begin
                rt_cnt   = rt_delay;
                pend_rgb = mdl_rgb;
            end
        end
    end

    // Output monitor: every accepted stream beat must match the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && bus.pix_valid && bus.pix_ready) begin
            pops++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL pop_unexpected observed=%06h expected=none", bus.pix_data);
            end else begin
                mon_e = sb.pop_front();
                check("pop_data", 32'(bus.pix_data), 32'(mon_e.rgb));
                check("pop_sof", 32'(bus.pix_sof), 32'(mon_e.sof));
                check("pop_eol", 32'(bus.pix_eol), 32'(mon_e.eol));
            end
        end
        if (rst_n && frame_done) frames++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_req(input int n, input string tag);
        int i;
        i = 0;
        while (req_cnt < n && i < 300) begin
            @(negedge clk);
            i++;
        end
        check(tag, 32'(req_cnt >= n), 32'd1);
        tick(1);
    endtask

    task automatic wait_pops(input int n, input string tag);
        int i;
        i = 0;
        while (pops < n && i < 300) begin
            @(negedge clk);
            i++;
        end
        check(tag, 32'(pops >= n), 32'd1);
        tick(1);
    endtask

    task automatic restart_frame();
        frame_restart = 1'b1;
        enable        = 1'b0;
        sb.delete();
        exp_x   = 0;
        exp_y   = 0;
        req_cnt = 0;
        pops    = 0;
        tick(1);
        frame_restart = 1'b0;
    endtask

    initial begin
        logic [15:0] exp_crc;
        bit found;
        int t0, t1;

        rst_n = 1'b0; enable = 1'b0; frame_restart = 1'b0; bus.pix_ready = 1'b0;
        tick(3);
        check("rst_pixel_valid", 32'(bus.pixel_valid), 32'd0);
        check("rst_pix_valid", 32'(bus.pix_valid), 32'd0);
        check("rst_pix_data", 32'(bus.pix_data), 32'd0);
        check("rst_pixel_xy", 32'({bus.pixel_x, bus.pixel_y}), 32'd0);
        check("rst_flags", 32'({frame_done, timeout_err}), 32'd0);
        check("rst_frame_crc", 32'(frame_crc), 32'd0);
        rst_n = 1'b1;
        tick(2);

        // Raster walk over a full 4x2 frame, 3-cycle answers, always ready.
        rt_delay = 3; bus.pix_ready = 1'b1; enable = 1'b1;
        wait_pops(8, "raster_8_pops");
        check("raster_frame_done", 32'(frames), 32'd1);
        wait_req(9, "raster_9th_req");
        check("raster_wrap_xy", 32'(last_x + last_y), 32'd0);
        enable = 1'b0;
        tick(15);
        check("raster_drained", 32'(sb.size()), 32'd0);

        // Timeout: no answer, result substituted TIMEOUT+1 WAIT cycles later.
        restart_frame();
        rt_never = 1; bus.pix_ready = 1'b0; enable = 1'b1;
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (bus.pixel_valid) found = 1;
        end
        check("to_req_seen", 32'(found), 32'd1);
        t0 = cyc;
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (bus.pix_valid) found = 1;
        end
        check("to_push_seen", 32'(found), 32'd1);
        t1 = cyc;
        check("to_latency", 32'(t1 - t0), 32'd17);
        check("to_err_set", 32'(timeout_err), 32'd1);
        tick(1);
        enable = 1'b0; bus.pix_ready = 1'b1;
        tick(40);
        check("to_drained", 32'(sb.size()), 32'd0);
        rt_never = 0;

        // Backpressure: exactly D pushes then stall; one pop admits one request.
        restart_frame();
        check("bp_err_cleared", 32'(timeout_err), 32'd0);
        rt_delay = 1; bus.pix_ready = 1'b0; enable = 1'b1;
        tick(40);
        check("bp_req_count", 32'(req_cnt), 32'(D));
        check("bp_pix_valid", 32'(bus.pix_valid), 32'd1);
        bus.pix_ready = 1'b1;
        tick(1);
        bus.pix_ready = 1'b0;
        tick(10);
        check("bp_req_after_pop", 32'(req_cnt), 32'(D + 1));
        enable = 1'b0; bus.pix_ready = 1'b1;
        tick(20);
        check("bp_pops", 32'(pops), 32'(D + 1));
        check("bp_drained", 32'(sb.size()), 32'd0);

        // Race: rt_done lands on the cycle the timer reaches TIMEOUT.
        pops = 0; req_cnt = 0; rt_delay = int'(TO) + 1; enable = 1'b1;
        wait_req(1, "race_req");
        enable = 1'b0;
        tick(25);
        check("race_pops", 32'(pops), 32'd1);
        check("race_no_err", 32'(timeout_err), 32'd0);

        // Abort: restart mid-WAIT, the late answer must be dropped.
        req_cnt = 0; rt_delay = 8; enable = 1'b1;
        wait_req(1, "abort_req");
        tick(2);
        late_fired = 0;
        restart_frame();
        tick(12);
        check("abort_late_done", 32'(late_fired), 32'd1);
        check("abort_fifo_empty", 32'(bus.pix_valid), 32'd0);
        check("abort_sb_empty", 32'(sb.size()), 32'd0);

        // Full frame of all-ones pixels for the CRC.
        rt_all_ones = 1; rt_delay = 1; req_cnt = 0; pops = 0; enable = 1'b1;
        wait_req(1, "crc_first_req");
        check("abort_next_xy", 32'(last_x + last_y), 32'd0);
        wait_pops(8, "crc_8_pops");
        enable = 1'b0;
        tick(10);
`ifdef PIXEL_SCHED_CRC_EN
        exp_crc = 16'hFFFF;
        repeat (8) exp_crc = crc_word(exp_crc, 24'hFFFFFF);
`else
        exp_crc = 16'h0000;
`endif
        check("frame_crc", 32'(frame_crc), 32'(exp_crc));

        // Asynchronous reset in the middle of traffic.
        rt_all_ones = 0; rt_delay = 3; enable = 1'b1;
        tick(9);
        rst_n = 1'b0;
        #1;
        check("midrst_outputs",
              32'({bus.pixel_valid, bus.pix_valid, timeout_err, frame_done}), 32'd0);
        check("midrst_xy", 32'({bus.pixel_x, bus.pixel_y}), 32'd0);
        check("midrst_crc", 32'(frame_crc), 32'd0);
        enable = 1'b0;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
